// File: rtl/vr_prep_eng.sv
// Prepare-stream engine: validates Prepare headers against replica state, forwards
// accepted messages to the log writer and issues a PrepareOK reply metadata beat.
module vr_prep_eng #(
  parameter int NOC_DATA_W     = 512,
  parameter int NOC_PADBYTES   = NOC_DATA_W / 8,
  parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES),
  parameter int REPLY_BYTES    = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,

  // udp_info layout: {src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0], data_length[15:0]}
  input  logic                      manage_prep_msg_val,
  input  logic [111:0]              manage_prep_pkt_info,
  output logic                      prep_manage_msg_rdy,

  input  logic                      manage_prep_req_val,
  input  logic [NOC_DATA_W-1:0]     manage_prep_req,
  input  logic                      manage_prep_req_last,
  input  logic [NOC_PADBYTES_W-1:0] manage_prep_req_padbytes,
  output logic                      prep_manage_req_rdy,

  input  logic [63:0]               curr_view,

  output logic                      prep_log_wr_val,
  output logic [NOC_DATA_W-1:0]     prep_log_wr_data,
  output logic                      prep_log_wr_last,
  output logic [NOC_PADBYTES_W-1:0] prep_log_wr_padbytes,
  output logic [63:0]               prep_log_wr_op_num,
  input  logic                      log_prep_wr_rdy,

  output logic                      prep_reply_val,
  output logic [111:0]              prep_reply_info,
  output logic [63:0]               prep_reply_view,
  output logic [63:0]               prep_reply_op_num,
  input  logic                      reply_prep_rdy,

  output logic                      prep_eng_rdy,
  output logic [31:0]               prep_drop_cnt
);

  // state   | meaning
  // IDLE    | waiting for the metadata beat
  // HDR     | first flit: check view/op, decide forward or drop
  // PAYLOAD | forwarding remaining flits to the log writer
  // DROP    | discarding remaining flits of a rejected message
  // REPLY   | presenting PrepareOK reply metadata
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    DROP    = 3'd3,
    REPLY   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [111:16] info_reg;
  logic [63:0]   view_reg, op_reg, last_op_num;
  logic [31:0]   drop_cnt;

  logic [63:0]   hdr_view, hdr_op;
  logic          accept;
  logic          latch_info, latch_hdr, drop_inc, commit_op;

  logic          unused_bits;
  assign unused_bits = ^manage_prep_pkt_info[15:0];

  assign hdr_view = manage_prep_req[NOC_DATA_W-1  -: 64];
  assign hdr_op   = manage_prep_req[NOC_DATA_W-65 -: 64];
  assign accept   = (hdr_view == curr_view) && (hdr_op == last_op_num + 64'd1);

  always_comb begin
    state_n             = state;
    prep_manage_msg_rdy = 1'b0;
    prep_manage_req_rdy = 1'b0;
    prep_log_wr_val     = 1'b0;
    prep_log_wr_op_num  = op_reg;
    prep_reply_val      = 1'b0;
    latch_info          = 1'b0;
    latch_hdr           = 1'b0;
    drop_inc            = 1'b0;
    commit_op           = 1'b0;
    case (state)
      IDLE: begin
        prep_manage_msg_rdy = 1'b1;
        if (manage_prep_msg_val) begin
          latch_info = 1'b1;
          state_n    = HDR;
        end
      end
      HDR: begin
        if (accept) begin
          prep_log_wr_val     = manage_prep_req_val;
          prep_manage_req_rdy = log_prep_wr_rdy;
          prep_log_wr_op_num  = hdr_op;
          if (manage_prep_req_val && log_prep_wr_rdy) begin
            latch_hdr = 1'b1;
            state_n   = manage_prep_req_last ? REPLY : PAYLOAD;
          end
        end else begin
          prep_manage_req_rdy = 1'b1;
          if (manage_prep_req_val) begin
            drop_inc = 1'b1;
            state_n  = manage_prep_req_last ? IDLE : DROP;
          end
        end
      end
      PAYLOAD: begin
        prep_log_wr_val     = manage_prep_req_val;
        prep_manage_req_rdy = log_prep_wr_rdy;
        if (manage_prep_req_val && log_prep_wr_rdy && manage_prep_req_last)
          state_n = REPLY;
      end
      DROP: begin
        prep_manage_req_rdy = 1'b1;
        if (manage_prep_req_val && manage_prep_req_last)
          state_n = IDLE;
      end
      REPLY: begin
        prep_reply_val = 1'b1;
        if (reply_prep_rdy) begin
          commit_op = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_op_num <= 64'd0;
      drop_cnt    <= 32'd0;
    end else begin
      state <= state_n;
      if (commit_op)
        last_op_num <= op_reg;
      if (drop_inc && (drop_cnt != 32'hFFFF_FFFF))
        drop_cnt <= drop_cnt + 32'd1;
    end
  end

  // Message context registers need no reset: they are only read in states reached after loading.
  always_ff @(posedge clk) begin
    if (latch_info)
      info_reg <= manage_prep_pkt_info[111:16];
    if (latch_hdr) begin
      view_reg <= hdr_view;
      op_reg   <= hdr_op;
    end
  end

  assign prep_log_wr_data     = manage_prep_req;
  assign prep_log_wr_last     = manage_prep_req_last;
  assign prep_log_wr_padbytes = manage_prep_req_padbytes;

  assign prep_reply_info   = {info_reg[79:48], info_reg[111:80],
                              info_reg[31:16], info_reg[47:32], 16'(REPLY_BYTES)};
  assign prep_reply_view   = view_reg;
  assign prep_reply_op_num = op_reg;

  assign prep_eng_rdy  = (state == IDLE);
  assign prep_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_vr_prep_eng.sv
// Directed bench for vr_prep_eng: accept/reject, backpressure, op wrap and mid-message reset.
module tb_vr_prep_eng;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         msg_val;
  logic [111:0] pkt_info;
  logic         prep_manage_msg_rdy;
  logic         req_val;
  logic [511:0] req;
  logic         req_last;
  logic [5:0]   req_pad;
  logic         prep_manage_req_rdy;
  logic [63:0]  curr_view;
  logic         prep_log_wr_val;
  logic [511:0] prep_log_wr_data;
  logic         prep_log_wr_last;
  logic [5:0]   prep_log_wr_padbytes;
  logic [63:0]  prep_log_wr_op_num;
  logic         log_rdy;
  logic         prep_reply_val;
  logic [111:0] prep_reply_info;
  logic [63:0]  prep_reply_view;
  logic [63:0]  prep_reply_op_num;
  logic         reply_rdy;
  logic         prep_eng_rdy;
  logic [31:0]  prep_drop_cnt;

  always #5 clk = ~clk;

  vr_prep_eng dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .manage_prep_msg_val      (msg_val),
    .manage_prep_pkt_info     (pkt_info),
    .prep_manage_msg_rdy      (prep_manage_msg_rdy),
    .manage_prep_req_val      (req_val),
    .manage_prep_req          (req),
    .manage_prep_req_last     (req_last),
    .manage_prep_req_padbytes (req_pad),
    .prep_manage_req_rdy      (prep_manage_req_rdy),
    .curr_view                (curr_view),
    .prep_log_wr_val          (prep_log_wr_val),
    .prep_log_wr_data         (prep_log_wr_data),
    .prep_log_wr_last         (prep_log_wr_last),
    .prep_log_wr_padbytes     (prep_log_wr_padbytes),
    .prep_log_wr_op_num       (prep_log_wr_op_num),
    .log_prep_wr_rdy          (log_rdy),
    .prep_reply_val           (prep_reply_val),
    .prep_reply_info          (prep_reply_info),
    .prep_reply_view          (prep_reply_view),
    .prep_reply_op_num        (prep_reply_op_num),
    .reply_prep_rdy           (reply_rdy),
    .prep_eng_rdy             (prep_eng_rdy),
    .prep_drop_cnt            (prep_drop_cnt)
  );

  localparam logic [111:0] INFO  = {32'h0A00_0001, 32'h0A00_0002, 16'h1234, 16'h5678, 16'h0040};
  localparam logic [111:0] RINFO = {32'h0A00_0002, 32'h0A00_0001, 16'h5678, 16'h1234, 16'd24};

  int n_checks = 0;
  int n_pass   = 0;
  bit tog      = 1'b0;

  logic [511:0] lq_data[$];
  logic         lq_last[$];
  logic [5:0]   lq_pad[$];
  logic [63:0]  lq_op[$];
  logic [63:0]  rq_view[$];
  logic [63:0]  rq_op[$];
  logic [111:0] rq_info[$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Handshakes are observed one time unit before each rising edge.
  always begin
    @(negedge clk); #4;
    if (rst_n && prep_log_wr_val && log_rdy) begin
      lq_data.push_back(prep_log_wr_data);
      lq_last.push_back(prep_log_wr_last);
      lq_pad.push_back(prep_log_wr_padbytes);
      lq_op.push_back(prep_log_wr_op_num);
    end
    if (rst_n && prep_reply_val && reply_rdy) begin
      rq_view.push_back(prep_reply_view);
      rq_op.push_back(prep_reply_op_num);
      rq_info.push_back(prep_reply_info);
    end
  end

  always @(negedge clk) if (tog) log_rdy = ~log_rdy;

  function automatic logic [511:0] mk_flit(input logic [63:0] view, input logic [63:0] op, input int idx);
    if (idx == 0)
      return {view, op, 64'hC0FF_EE00 + op, {10{32'h1111_0000}}};
    return {16{32'hD000_0000 + op[31:0] * 32'd16 + 32'(idx)}};
  endfunction

  task automatic clear_q();
    lq_data.delete(); lq_last.delete(); lq_pad.delete(); lq_op.delete();
    rq_view.delete(); rq_op.delete(); rq_info.delete();
  endtask

  task automatic hs_msg();
    bit ok = 1'b0;
    int n  = 0;
    msg_val  = 1'b1;
    pkt_info = INFO;
    while (!ok && n < 50) begin #4; ok = prep_manage_msg_rdy; @(negedge clk); n++; end
    msg_val = 1'b0;
    if (!ok) check("msg_timeout", 0, 1);
  endtask

  task automatic hs_flit(input logic [511:0] d, input logic l, input logic [5:0] p);
    bit ok = 1'b0;
    int n  = 0;
    req_val = 1'b1; req = d; req_last = l; req_pad = p;
    while (!ok && n < 50) begin #4; ok = prep_manage_req_rdy; @(negedge clk); n++; end
    req_val = 1'b0; req_last = 1'b0;
    if (!ok) check("flit_timeout", 0, 1);
  endtask

  task automatic send_msg(input logic [63:0] view, input logic [63:0] op, input int nf, input logic [5:0] pad);
    hs_msg();
    for (int i = 0; i < nf; i++)
      hs_flit(mk_flit(view, op, i), i == nf - 1, (i == nf - 1) ? pad : 6'd0);
  endtask

  // Called right after send_msg returns for a message that must be accepted.
  task automatic expect_accept(input string tag, input logic [63:0] view, input logic [63:0] op,
                               input int nf, input logic [5:0] pad);
    check({tag, "_reply_val"}, prep_reply_val, 1);
    check({tag, "_busy"}, prep_eng_rdy, 0);
    @(negedge clk);
    check({tag, "_eng_rdy"}, prep_eng_rdy, 1);
    check({tag, "_log_cnt"}, lq_data.size(), nf);
    for (int i = 0; i < nf && i < lq_data.size(); i++) begin
      check({tag, "_log_data"}, lq_data[i], mk_flit(view, op, i));
      check({tag, "_log_last"}, lq_last[i], i == nf - 1);
      check({tag, "_log_pad"}, lq_pad[i], (i == nf - 1) ? pad : 6'd0);
      check({tag, "_log_op"}, lq_op[i], op);
    end
    check({tag, "_reply_cnt"}, rq_op.size(), 1);
    if (rq_op.size() > 0) begin
      check({tag, "_reply_view"}, rq_view[0], view);
      check({tag, "_reply_op"}, rq_op[0], op);
      check({tag, "_reply_info"}, rq_info[0], RINFO);
    end
    clear_q();
  endtask

  task automatic expect_drop(input string tag, input logic [31:0] drops);
    repeat (2) @(negedge clk);
    check({tag, "_log_cnt"}, lq_data.size(), 0);
    check({tag, "_reply_cnt"}, rq_op.size(), 0);
    check({tag, "_drop_cnt"}, prep_drop_cnt, drops);
    check({tag, "_eng_rdy"}, prep_eng_rdy, 1);
    clear_q();
  endtask

  initial begin
    rst_n = 1'b0; msg_val = 1'b0; pkt_info = '0; req_val = 1'b0; req = '0;
    req_last = 1'b0; req_pad = '0; curr_view = 64'd3; log_rdy = 1'b1; reply_rdy = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_msg_rdy", prep_manage_msg_rdy, 1);
    check("rst_req_rdy", prep_manage_req_rdy, 0);
    check("rst_log_val", prep_log_wr_val, 0);
    check("rst_reply_val", prep_reply_val, 0);
    check("rst_eng_rdy", prep_eng_rdy, 1);
    check("rst_drop_cnt", prep_drop_cnt, 0);

    send_msg(64'd3, 64'd1, 1, 6'd7);
    expect_accept("single", 64'd3, 64'd1, 1, 6'd7);

    tog = 1'b1;
    send_msg(64'd3, 64'd2, 3, 6'd5);
    tog = 1'b0; log_rdy = 1'b1;
    expect_accept("bp3", 64'd3, 64'd2, 3, 6'd5);

    send_msg(64'd2, 64'd3, 2, 6'd0);
    expect_drop("stale_view", 1);
    send_msg(64'd3, 64'd3, 1, 6'd1);
    expect_accept("after_stale", 64'd3, 64'd3, 1, 6'd1);

    send_msg(64'd3, 64'd5, 1, 6'd0);
    expect_drop("op_gap", 2);
    send_msg(64'd3, 64'd4, 2, 6'd2);
    expect_accept("after_gap", 64'd3, 64'd4, 2, 6'd2);

    force dut.last_op_num = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    send_msg(64'd3, 64'd0, 1, 6'd3);
    release dut.last_op_num;
    expect_accept("wrap", 64'd3, 64'd0, 1, 6'd3);

    // Mid-message reset: header accepted, then reset while a payload flit is offered.
    hs_msg();
    hs_flit(mk_flit(64'd3, 64'd1, 0), 1'b0, 6'd0);
    req_val = 1'b1; req = mk_flit(64'd3, 64'd1, 1); req_last = 1'b0;
    #4;
    check("pre_rst_payload_val", prep_log_wr_val, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_log_val", prep_log_wr_val, 0);
    check("midrst_reply_val", prep_reply_val, 0);
    check("midrst_req_rdy", prep_manage_req_rdy, 0);
    check("midrst_eng_rdy", prep_eng_rdy, 1);
    check("midrst_drop_cnt", prep_drop_cnt, 0);
    req_val = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    clear_q();
    send_msg(64'd3, 64'd1, 1, 6'd4);
    expect_accept("post_rst", 64'd3, 64'd1, 1, 6'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
